// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    // Operation encodings as presented on the op port.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Control FSM states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = mdu_pkg::MDU_WIDTH
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] Rs;
    logic [WIDTH-1:0] Rt;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, Rs, Rt, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, Rs, Rt, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_iter_core.sv
// Unsigned one-bit-per-clock shift-add multiplier / restoring divider datapath.
// Multiply: upper:lower holds the running product, multiplier bits retire from lower[0].
// Divide:   upper holds the partial remainder, lower shifts dividend out and quotient in.
module mdu_iter_core import mdu_pkg::*; #(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] hi_raw,
    output logic [WIDTH-1:0] lo_raw
);

    logic [WIDTH-1:0] upper_q, upper_d;
    logic [WIDTH-1:0] lower_q, lower_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Next datapath value for one multiply or divide iteration.
    always_comb begin
        upper_d = upper_q;
        lower_d = lower_q;
        sum     = {1'b0, upper_q} + (lower_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
        shifted = {upper_q, lower_q[WIDTH-1]};
        // Partial remainder stays below the divisor, so trial[WIDTH] is a clean borrow flag.
        trial   = shifted - {1'b0, b_q};
        if (load) begin
            upper_d = '0;
            lower_d = mag_a;
        end else if (step) begin
            if (is_div) begin
                if (!trial[WIDTH]) begin
                    upper_d = trial[WIDTH-1:0];
                    lower_d = {lower_q[WIDTH-2:0], 1'b1};
                end else begin
                    upper_d = shifted[WIDTH-1:0];
                    lower_d = {lower_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                upper_d = sum[WIDTH:1];
                lower_d = {sum[0], lower_q[WIDTH-1:1]};
            end
        end
    end

    // Datapath registers; contents are only meaningful after a load.
    always_ff @(posedge clk) begin
        upper_q <= upper_d;
        lower_q <= lower_d;
        if (load) begin
            b_q <= mag_b;
        end
    end

    assign hi_raw = upper_q;
    assign lo_raw = lower_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Takes WIDTH+2 edges from start to done: load, WIDTH iterations, sign fix-up.
module mult_div_unit import mdu_pkg::*; #(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_div_unit_if.slave        bus
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q;

    logic [1:0]       op_q;
    logic             sa_q, sb_q, zero_q;
    logic [WIDTH-1:0] rs_q;

    logic             in_signed, in_sa, in_sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             load, step;
    logic [WIDTH-1:0] hi_raw, lo_raw;

    logic             neg_res;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign in_signed = op_is_signed(bus.op);
    assign in_sa     = in_signed & bus.Rs[WIDTH-1];
    assign in_sb     = in_signed & bus.Rt[WIDTH-1];
    assign mag_a     = in_sa ? -bus.Rs : bus.Rs;
    assign mag_b     = in_sb ? -bus.Rt : bus.Rt;
    assign load      = (state_q == S_IDLE) && bus.start;
    assign step      = (state_q == S_RUN);

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .load   (load),
        .step   (step),
        .is_div (op_is_div(op_q)),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .hi_raw (hi_raw),
        .lo_raw (lo_raw)
    );

    // Latch operand signs and the original dividend when an op is accepted.
    always_ff @(posedge clk) begin
        if (load) begin
            op_q   <= bus.op;
            sa_q   <= in_sa;
            sb_q   <= in_sb;
            zero_q <= (bus.Rt == '0);
            rs_q   <= bus.Rs;
        end
    end

    // Sign correction and divide-by-zero override of the unsigned core result.
    always_comb begin
        neg_res  = op_is_signed(op_q) & (sa_q ^ sb_q);
        prod_raw = {hi_raw, lo_raw};
        prod_fix = neg_res ? -prod_raw : prod_raw;
        if (!op_is_div(op_q)) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (zero_q) begin
            res_hi = rs_q;
            res_lo = '1;
        end else begin
            // Quotient truncates toward zero; remainder follows the dividend's sign.
            res_hi = (op_is_signed(op_q) & sa_q) ? -hi_raw : hi_raw;
            res_lo = neg_res ? -lo_raw : lo_raw;
        end
    end

    // FSM, iteration counter and HI/LO next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    // Moves to HI/LO only land when no op is being launched.
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and architectural state registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= (state_q == S_FIX);
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
